glyph_matcher: RTL and testbench

//  Template-matching recogniser placed downstream of the digit glyph ROMs (prom_0..prom_9, 16x16, row-wise 0:15).
//  On start, steps through every row of every digit template and compares each against the user-drawn 16x16 bitmap.

---
 rtl/glyph_matcher_pkg.sv | 19 +
 rtl/glyph_matcher_row_popcount16.sv | 18 +
 rtl/glyph_matcher.sv | 178 +++++++++++++++++
 tb/tb_glyph_matcher.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_matcher_pkg.sv
// Shared types and constants for the glyph template matcher.
package glyph_matcher_pkg;

   localparam int          DEF_N_DIGITS = 10;
   localparam int          GLYPH_ROWS   = 16;
   localparam int          GLYPH_COLS   = 16;
   localparam int          SCORE_W      = 9;
   localparam int          MIN_SCORE    = 200;
   localparam logic [3:0]  DIGIT_REJECT = 4'hF;
   localparam logic [3:0]  FLUSH_LAST   = 4'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/glyph_matcher_row_popcount16.sv
// Counts agreeing pixels between a template row and a drawn row (XNOR popcount).
module row_popcount16 (
   input  logic [15:0] row_a,
   input  logic [15:0] row_b,
   output logic [4:0]  agree_cnt
);

   logic [15:0] agree;

   always_comb begin
      agree     = ~(row_a ^ row_b);
      agree_cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         agree_cnt = agree_cnt + {4'd0, agree[i]};
      end
   end

endmodule

// File: rtl/glyph_matcher.sv
// Scans every digit template row by row, scores each against the drawn bitmap, reports the best digit.
// Optional macro GLYPH_MATCH_REJECT_EN: report DIGIT_REJECT when the best score is below MIN_SCORE.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_SCAN  | one template row per cycle, all digits
// S_FLUSH | drains score pipeline (3 cycles) and settles the best digit
// S_DONE  | done pulse, result registers just loaded
module glyph_matcher
   import glyph_matcher_pkg::*;
#(
   parameter int N_DIGITS = DEF_N_DIGITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic [3:0]          tpl_sel,
   output logic [3:0]          tpl_row_addr,
   input  logic [15:0]         tpl_row,
   output logic [3:0]          bmp_row_addr,
   input  logic [15:0]         bmp_row,
   output logic                done,
   output logic [3:0]          result_digit,
   output logic [SCORE_W-1:0]  best_score
);

   state_t               state_q, state_d;
   logic [3:0]           digit_q, digit_d;
   logic [3:0]           row_q, row_d;

   logic [4:0]           sc_q, sc_d, row_score;
   logic                 sc_valid_q, sc_valid_d;
   logic                 sc_last_q, sc_last_d;
   logic [3:0]           sc_digit_q, sc_digit_d;

   logic [SCORE_W-1:0]   acc_q, acc_d;
   logic [SCORE_W-1:0]   tot_q, tot_d;
   logic                 tot_valid_q, tot_valid_d;
   logic [3:0]           tot_digit_q, tot_digit_d;

   logic [SCORE_W-1:0]   best_q, best_d;
   logic [3:0]           best_digit_q, best_digit_d;
   logic [SCORE_W-1:0]   score_out_q, score_out_d;
   logic [3:0]           result_q, result_d;

   row_popcount16 u_popcount (
      .row_a     (tpl_row),
      .row_b     (bmp_row),
      .agree_cnt (row_score)
   );

   always_comb begin
      state_d      = state_q;
      digit_d      = digit_q;
      row_d        = row_q;
      sc_d         = row_score;
      sc_valid_d   = (state_q == S_SCAN);
      sc_last_d    = (row_q == 4'(GLYPH_ROWS - 1));
      sc_digit_d   = digit_q;
      acc_d        = acc_q;
      tot_d        = tot_q;
      tot_valid_d  = 1'b0;
      tot_digit_d  = tot_digit_q;
      best_d       = best_q;
      best_digit_d = best_digit_q;
      score_out_d  = score_out_q;
      result_d     = result_q;

      // Accumulate the piped row score; a finished digit moves to the compare stage.
      if (sc_valid_q) begin
         if (sc_last_q) begin
            tot_d       = acc_q + {4'd0, sc_q};
            tot_valid_d = 1'b1;
            tot_digit_d = sc_digit_q;
            acc_d       = '0;
         end else begin
            acc_d = acc_q + {4'd0, sc_q};
         end
      end

      // Strict compare: ties keep the earlier (lower) digit.
      if (tot_valid_q && (tot_q > best_q)) begin
         best_d       = tot_q;
         best_digit_d = tot_digit_q;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_SCAN;
               digit_d      = 4'd0;
               row_d        = 4'd0;
               acc_d        = '0;
               best_d       = '0;
               best_digit_d = 4'd0;
               tot_valid_d  = 1'b0;
            end
         end
         S_SCAN: begin
            row_d = row_q + 4'd1;
            if (row_q == 4'(GLYPH_ROWS - 1)) begin
               row_d = 4'd0;
               if (digit_q == 4'(N_DIGITS - 1)) begin
                  state_d = S_FLUSH;
               end else begin
                  digit_d = digit_q + 4'd1;
               end
            end
         end
         S_FLUSH: begin
            row_d = row_q + 4'd1;
            if (row_q == FLUSH_LAST) begin
               state_d     = S_DONE;
               row_d       = 4'd0;
               digit_d     = 4'd0;
               score_out_d = best_q;
`ifdef GLYPH_MATCH_REJECT_EN
               result_d    = (best_q < SCORE_W'(MIN_SCORE)) ? DIGIT_REJECT : best_digit_q;
`else
               result_d    = best_digit_q;
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         digit_q      <= 4'd0;
         row_q        <= 4'd0;
         sc_q         <= 5'd0;
         sc_valid_q   <= 1'b0;
         sc_last_q    <= 1'b0;
         sc_digit_q   <= 4'd0;
         acc_q        <= '0;
         tot_q        <= '0;
         tot_valid_q  <= 1'b0;
         tot_digit_q  <= 4'd0;
         best_q       <= '0;
         best_digit_q <= 4'd0;
         score_out_q  <= '0;
         result_q     <= DIGIT_REJECT;
      end else begin
         state_q      <= state_d;
         digit_q      <= digit_d;
         row_q        <= row_d;
         sc_q         <= sc_d;
         sc_valid_q   <= sc_valid_d;
         sc_last_q    <= sc_last_d;
         sc_digit_q   <= sc_digit_d;
         acc_q        <= acc_d;
         tot_q        <= tot_d;
         tot_valid_q  <= tot_valid_d;
         tot_digit_q  <= tot_digit_d;
         best_q       <= best_d;
         best_digit_q <= best_digit_d;
         score_out_q  <= score_out_d;
         result_q     <= result_d;
      end
   end

   assign busy         = (state_q == S_SCAN) || (state_q == S_FLUSH);
   assign done         = (state_q == S_DONE);
   assign tpl_sel      = digit_q;
   assign tpl_row_addr = row_q;
   assign bmp_row_addr = row_q;
   assign result_digit = result_q;
   assign best_score   = score_out_q;

endmodule

// File: tb/tb_glyph_matcher.sv
// Directed bench for glyph_matcher; templates come from a hashed stand-in for the digit ROMs.
module tb_glyph_matcher;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy;
   logic [3:0]  tpl_sel;
   logic [3:0]  tpl_row_addr;
   logic [15:0] tpl_row;
   logic [3:0]  bmp_row_addr;
   logic [15:0] bmp_row;
   logic        done;
   logic [3:0]  result_digit;
   logic [8:0]  best_score;

   logic [15:0] bmp_mem [16];
   bit          tie_mode = 1'b0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] tpl_fn(input logic [3:0] d, input logic [3:0] r);
      logic [31:0] h;
      h = (32'(d) * 32'd16 + 32'(r) + 32'd1) * 32'h9E3779B1;
      h = h ^ (h >> 13);
      h = h * 32'h85EBCA6B;
      h = h ^ (h >> 16);
      return h[31:16] ^ h[15:0];
   endfunction

   assign tpl_row = tpl_fn((tie_mode && tpl_sel == 4'd5) ? 4'd2 : tpl_sel, tpl_row_addr);
   assign bmp_row = bmp_mem[bmp_row_addr];

   glyph_matcher dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .busy         (busy),
      .tpl_sel      (tpl_sel),
      .tpl_row_addr (tpl_row_addr),
      .tpl_row      (tpl_row),
      .bmp_row_addr (bmp_row_addr),
      .bmp_row      (bmp_row),
      .done         (done),
      .result_digit (result_digit),
      .best_score   (best_score)
   );

   task automatic load_glyph(input logic [3:0] d);
      for (int r = 0; r < 16; r++) bmp_mem[r] = tpl_fn(d, 4'(r));
   endtask

   // Called #1 after a clock edge; start is sampled at the next edge (cycle 0 follows it).
   task automatic run_scan(input int pulse_at, input int rst_at, input bit chk_busy, input int tail,
                           output int done_cyc, output int n_done,
                           output logic [3:0] res, output logic [8:0] sc);
      int cyc;
      cyc = 0; n_done = 0; done_cyc = -1; res = 4'h0; sc = 9'h0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (cyc < 400) begin
         if (done) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = cyc; res = result_digit; sc = best_score;
            end
         end
         if (chk_busy && cyc <= 163) begin
            total++;
            if (busy !== (cyc < 163)) begin
               bad++;
               $display("FAIL busy_cycle cyc=%0d got=%b want=%b", cyc, busy, (cyc < 163));
            end
         end
         if (cyc == rst_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || result_digit !== 4'hF || best_score !== 9'd0
                || tpl_sel !== 4'd0) begin
               bad++;
               $display("FAIL rst_mid_scan got busy=%b done=%b res=%h score=%0d sel=%0d want 0 0 f 0 0",
                        busy, done, result_digit, best_score, tpl_sel);
            end
            for (int k = 0; k < 200; k++) begin
               @(posedge clk); #1;
               if (done) n_done++;
            end
            return;
         end
         start = (cyc == pulse_at);
         if (cyc == 40 && pulse_at == 40) begin
            total++;
            if (tpl_sel !== 4'd2 || tpl_row_addr !== 4'd8 || bmp_row_addr !== 4'd8) begin
               bad++;
               $display("FAIL row40_addr got sel=%0d row=%0d bmp=%0d want 2 8 8",
                        tpl_sel, tpl_row_addr, bmp_row_addr);
            end
         end
         if (done_cyc >= 0 && cyc >= done_cyc + tail) break;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || tpl_sel !== 4'd0 || tpl_row_addr !== 4'd0
          || result_digit !== 4'hF || best_score !== 9'd0) begin
         bad++;
         $display("FAIL reset_state got busy=%b done=%b sel=%0d row=%0d res=%h score=%0d want 0 0 0 0 f 0",
                  busy, done, tpl_sel, tpl_row_addr, result_digit, best_score);
      end
   endtask

   task automatic test_exact_match();
      int dc, nd; logic [3:0] res; logic [8:0] sc;
      load_glyph(4'd3);
      run_scan(-1, -1, 1'b1, 0, dc, nd, res, sc);
      total++;
      if (dc !== 163) begin bad++; $display("FAIL exact_latency got=%0d want=163", dc); end
      total++;
      if (res !== 4'd3 || sc !== 9'd256) begin
         bad++; $display("FAIL exact_result got digit=%0d score=%0d want 3 256", res, sc);
      end
   endtask

   task automatic test_noisy_match();
      int dc, nd; logic [3:0] res; logic [8:0] sc;
      @(posedge clk); #1;
      load_glyph(4'd8);
      for (int r = 0; r < 10; r++) bmp_mem[r][r] = ~bmp_mem[r][r];
      run_scan(-1, -1, 1'b0, 0, dc, nd, res, sc);
      total++;
      if (res !== 4'd8 || sc !== 9'd246) begin
         bad++; $display("FAIL noisy_result got digit=%0d score=%0d want 8 246", res, sc);
      end
   endtask

   task automatic test_blank_bitmap();
      int dc, nd, s, best, bd; logic [3:0] res, exp_d; logic [8:0] sc;
      best = -1; bd = 0;
      for (int d = 0; d < 10; d++) begin
         s = 0;
         for (int r = 0; r < 16; r++) s += $countones(~tpl_fn(4'(d), 4'(r)));
         if (s > best) begin best = s; bd = d; end
      end
      exp_d = 4'(bd);
`ifdef GLYPH_MATCH_REJECT_EN
      if (best < 200) exp_d = 4'hF;
`endif
      @(posedge clk); #1;
      for (int r = 0; r < 16; r++) bmp_mem[r] = 16'h0000;
      run_scan(-1, -1, 1'b0, 0, dc, nd, res, sc);
      total++;
      if (res !== exp_d || sc !== 9'(best)) begin
         bad++; $display("FAIL blank_result got digit=%0d score=%0d want %0d %0d", res, sc, exp_d, best);
      end
   endtask

   task automatic test_tie();
      int dc, nd; logic [3:0] res; logic [8:0] sc;
      @(posedge clk); #1;
      tie_mode = 1'b1;
      load_glyph(4'd2);
      run_scan(-1, -1, 1'b0, 0, dc, nd, res, sc);
      tie_mode = 1'b0;
      total++;
      if (res !== 4'd2 || sc !== 9'd256) begin
         bad++; $display("FAIL tie_result got digit=%0d score=%0d want 2 256", res, sc);
      end
   endtask

   task automatic test_start_ignored_and_rst();
      int dc, nd; logic [3:0] res; logic [8:0] sc;
      @(posedge clk); #1;
      load_glyph(4'd6);
      run_scan(40, -1, 1'b0, 20, dc, nd, res, sc);
      total++;
      if (dc !== 163 || nd !== 1) begin
         bad++; $display("FAIL start_midscan got done_cyc=%0d n_done=%0d want 163 1", dc, nd);
      end
      total++;
      if (res !== 4'd6) begin bad++; $display("FAIL start_midscan_digit got=%0d want=6", res); end
      @(posedge clk); #1;
      run_scan(-1, 90, 1'b0, 0, dc, nd, res, sc);
      total++;
      if (nd !== 0) begin bad++; $display("FAIL rst_no_done got=%0d want=0", nd); end
   endtask

   task automatic test_back_to_back();
      int dc, nd; logic [3:0] res; logic [8:0] sc;
      @(posedge clk); #1;
      load_glyph(4'd1);
      run_scan(-1, -1, 1'b1, 0, dc, nd, res, sc);
      total++;
      if (dc !== 163 || res !== 4'd1 || sc !== 9'd256) begin
         bad++; $display("FAIL b2b_first got cyc=%0d digit=%0d score=%0d want 163 1 256", dc, res, sc);
      end
      @(posedge clk); #1;
      run_scan(-1, -1, 1'b1, 0, dc, nd, res, sc);
      total++;
      if (dc !== 163 || res !== 4'd1 || sc !== 9'd256) begin
         bad++; $display("FAIL b2b_second got cyc=%0d digit=%0d score=%0d want 163 1 256", dc, res, sc);
      end
      // start raised during the done cycle must not launch a scan
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL start_in_done got busy=%b done=%b want 0 0", busy, done);
      end
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL start_in_done_later got busy=%b want 0", busy); end
   endtask

   initial begin
      for (int r = 0; r < 16; r++) bmp_mem[r] = 16'h0000;
      test_reset();
      test_exact_match();
      test_noisy_match();
      test_blank_bitmap();
      test_tie();
      test_start_ignored_and_rst();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
